// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one simple-dual-port BRAM
// (1-cycle registered read) between NUM_REQ requesters. At most one access
// (read or write) is granted per cycle; read data returns one cycle after
// the read grant together with a one-hot rvalid strobe.
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt
// high in the same cycle; the access completes at the clock edge that ends
// that cycle. Dropping req before gnt withdraws the request; keeping req
// high after gnt issues a fresh, independent access.
module bram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int NUM_REQ    = 2,
    localparam int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [DATA_WIDTH-1:0]            bram_data,
    output logic [ADDRESS_WIDTH-1:0]         bram_wraddress,
    output logic                             bram_wren,
    output logic [ADDRESS_WIDTH-1:0]         bram_rdaddress,
    input  logic [DATA_WIDTH-1:0]            bram_q
);

    localparam int LAST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Most recent grantee and the requester whose read is returning.
    logic [LAST_W-1:0]        last;
    logic [NUM_REQ-1:0]       rd_pend;

    // Address/data of the previous winner, shown on the BRAM ports when idle.
    logic [ADDRESS_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0]    hold_data;

    logic [LAST_W-1:0]        winner;
    logic                     any_req;
    logic                     grant_valid;
    logic [ADDRESS_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0]    win_data;
    logic                     win_we;

    // Round-robin pick: scan from the farthest slot back to last+1 so the
    // final hit is the nearest requester after the previous grantee.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) begin
                winner  = LAST_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    // Select the winner's access fields; grants are suppressed during reset.
    always_comb begin
        grant_valid = resetn && any_req;
        win_addr    = addr[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        win_data    = wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        win_we      = we[winner];
    end

    // Drive grant, BRAM ports and read return.
    always_comb begin
        gnt            = grant_valid ? (NUM_REQ'(1) << winner) : '0;
        bram_wren      = grant_valid && win_we;
        bram_rdaddress = grant_valid ? win_addr : hold_addr;
        bram_wraddress = grant_valid ? win_addr : hold_addr;
        bram_data      = grant_valid ? win_data : hold_data;
        rvalid         = resetn ? rd_pend : '0;
        rdata          = bram_q;
    end

    // Arbiter state: advance pointer on grant, track the outstanding read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last      <= LAST_W'(NUM_REQ - 1);
            rd_pend   <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else if (any_req) begin
            last      <= winner;
            hold_addr <= win_addr;
            hold_data <= win_data;
            rd_pend   <= win_we ? '0 : (NUM_REQ'(1) << winner);
        end else begin
            rd_pend   <= '0;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter (NUM_REQ=4, 8-bit x 256 BRAM).
// A behavioural BRAM sits on the DUT's BRAM ports; a reference model tracks
// round-robin priority by distance from the last grantee, memory contents,
// and expected read data in a queue.
module tb_bram_arbiter;

    localparam int DW = 8;
    localparam int DEPTH = 256;
    localparam int NR = 4;
    localparam int AW = 8;

    logic            clock;
    logic            resetn;
    logic [NR-1:0]   req;
    logic [NR-1:0]   we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   rvalid;
    logic [DW-1:0]   rdata;
    logic [DW-1:0]   bram_data;
    logic [AW-1:0]   bram_wraddress;
    logic            bram_wren;
    logic [AW-1:0]   bram_rdaddress;
    logic [DW-1:0]   bram_q;

    bram_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
        .clock(clock), .resetn(resetn), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .bram_data(bram_data), .bram_wraddress(bram_wraddress),
        .bram_wren(bram_wren), .bram_rdaddress(bram_rdaddress),
        .bram_q(bram_q)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural BRAM: write on wren, registered read every cycle.
    logic [DW-1:0] bram_mem [DEPTH];
    always @(posedge clock) begin
        if (bram_wren) bram_mem[bram_wraddress] <= bram_data;
        bram_q <= bram_mem[bram_rdaddress];
    end

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last;
    int            m_pend;
    logic [AW-1:0] m_hold_addr;
    logic [DW-1:0] m_hold_data;
    logic [DW-1:0] exp_q[$];
    int            gcount [NR];
    int            since [NR];
    int            max_wait;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner = requesting index with the smallest distance past the last grantee.
    function automatic int model_winner(input logic [NR-1:0] r, input int last_g);
        int best, bestd, d;
        best = -1;
        bestd = NR + 1;
        for (int i = 0; i < NR; i++) begin
            if (r[i]) begin
                d = (i - last_g - 1 + 2 * NR) % NR;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_last = NR - 1;
        m_pend = -1;
        m_hold_addr = '0;
        m_hold_data = '0;
        exp_q.delete();
    endtask

    task automatic clear_fairness();
        for (int i = 0; i < NR; i++) begin
            gcount[i] = 0;
            since[i] = 0;
        end
        max_wait = 0;
    endtask

    // One clock cycle with reset released: drive, check mid-cycle, update model.
    task automatic cyc(input logic [NR-1:0] r, input logic [NR-1:0] w,
                       input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                       input bit pull_reset);
        int win;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        req = r; we = w; addr = a; wdata = d;
        win = model_winner(r, m_last);
        wa = (win >= 0) ? a[win*AW +: AW] : m_hold_addr;
        wd = (win >= 0) ? d[win*DW +: DW] : m_hold_data;
        @(negedge clock);
        check("gnt", {28'd0, gnt}, (win < 0) ? 32'd0 : (32'd1 << win));
        check("bram_wren", {31'd0, bram_wren}, {31'd0, (win >= 0) && w[win]});
        check("bram_rdaddress", {24'd0, bram_rdaddress}, {24'd0, wa});
        if (win < 0 || w[win]) begin
            check("bram_wraddress", {24'd0, bram_wraddress}, {24'd0, wa});
            check("bram_data", {24'd0, bram_data}, {24'd0, wd});
        end
        check("rvalid", {28'd0, rvalid}, (m_pend < 0) ? 32'd0 : (32'd1 << m_pend));
        if (m_pend >= 0) begin
            if (exp_q.size() == 0) check("exp_q_nonempty", 32'd0, 32'd1);
            else check("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
        end
        for (int i = 0; i < NR; i++) begin
            if (i == win) begin
                gcount[i]++;
                since[i] = 0;
            end else if (r[i]) begin
                since[i]++;
                if (since[i] > max_wait) max_wait = since[i];
            end
        end
        if (pull_reset) resetn = 1'b0;
        @(posedge clock);
        if (!resetn) begin
            model_reset();
        end else if (win >= 0) begin
            m_last = win;
            m_hold_addr = wa;
            m_hold_data = wd;
            if (w[win]) begin
                m_mem[wa] = wd;
                m_pend = -1;
            end else begin
                m_pend = win;
                exp_q.push_back(m_mem[wa]);
            end
        end else begin
            m_pend = -1;
        end
        #1;
    endtask

    // A cycle held in reset with random requests: nothing may be granted.
    task automatic reset_cycle();
        resetn = 1'b0;
        req = NR'($urandom_range(0, 15));
        we = NR'($urandom_range(0, 15));
        addr = $urandom;
        wdata = $urandom;
        @(negedge clock);
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_wren", {31'd0, bram_wren}, 32'd0);
        check("rst_rvalid", {28'd0, rvalid}, 32'd0);
        @(posedge clock);
        model_reset();
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) reset_cycle();
        resetn = 1'b1;
        req = '0;
    endtask

    function automatic logic [NR*AW-1:0] pa(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        return {16'h0000, a1, a0};
    endfunction

    function automatic logic [NR*DW-1:0] pd(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        return {16'h0000, d1, d0};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bram_mem[i] = '0;
            m_mem[i] = '0;
        end
        bram_q = '0;
        resetn = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        model_reset();
        clear_fairness();
        #1;
        do_reset(3);

        // Single write then read by requester 0.
        cyc(4'b0001, 4'b0001, pa(8'h10, 8'h00), pd(8'hA5, 8'h00), 1'b0);
        cyc(4'b0001, 4'b0000, pa(8'h10, 8'h00), pd(8'h00, 8'h00), 1'b0);
        cyc(4'b0000, 4'b0000, '0, '0, 1'b0);

        // Preload, reset, then two-way contention on reads.
        cyc(4'b0001, 4'b0001, pa(8'h01, 8'h00), pd(8'h11, 8'h00), 1'b0);
        cyc(4'b0001, 4'b0001, pa(8'h02, 8'h00), pd(8'h22, 8'h00), 1'b0);
        do_reset(2);
        clear_fairness();
        for (int i = 0; i < 8; i++)
            cyc(4'b0011, 4'b0000, pa(8'h01, 8'h02), '0, 1'b0);
        cyc(4'b0000, 4'b0000, '0, '0, 1'b0);
        check("contention_g0", gcount[0], 4);
        check("contention_g1", gcount[1], 4);

        // Four-way fairness over 16 cycles.
        do_reset(1);
        clear_fairness();
        for (int i = 0; i < 16; i++)
            cyc(4'b1111, NR'($urandom_range(0, 15)), {8'h33, 8'h22, 8'h11, 8'h01}, $urandom, 1'b0);
        cyc(4'b0000, 4'b0000, '0, '0, 1'b0);
        for (int i = 0; i < NR; i++) check("fair_count", gcount[i], 4);
        check("fair_max_wait_le3", {31'd0, max_wait <= 3}, 32'd1);

        // Write by requester 1, read of same address by requester 0 next cycle.
        cyc(4'b0010, 4'b0010, pa(8'h00, 8'h80), pd(8'h00, 8'h3C), 1'b0);
        cyc(4'b0001, 4'b0000, pa(8'h80, 8'h00), '0, 1'b0);
        cyc(4'b0000, 4'b0000, '0, '0, 1'b0);

        // Reset pulled while a read by requester 1 is in flight.
        cyc(4'b0010, 4'b0000, pa(8'h00, 8'h02), '0, 1'b1);
        do_reset(1);
        // First contention after release goes to 0; requester 1 then withdraws.
        cyc(4'b0011, 4'b0010, pa(8'h40, 8'h40), pd(8'h00, 8'hEE), 1'b0);
        cyc(4'b0001, 4'b0000, pa(8'h40, 8'h00), '0, 1'b0);
        cyc(4'b0000, 4'b0000, '0, '0, 1'b0);
        check("withdraw_mem", {24'd0, m_mem[8'h40]}, 32'd0);

        // Randomized traffic over a small address window to force reuse.
        for (int i = 0; i < 400; i++) begin
            logic [NR*AW-1:0] ra;
            for (int j = 0; j < NR; j++) ra[j*AW +: AW] = AW'($urandom_range(0, 15));
            cyc(NR'($urandom_range(0, 15)), NR'($urandom_range(0, 15)), ra, $urandom, 1'b0);
        end
        cyc(4'b0000, 4'b0000, '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one simple-dual-port BRAM (DATA_WIDTH x DEPTH, 1-cycle registered read) between NUM_REQ requesters, e.g. CPU fetch/load-store and a DMA/video fetcher.
- Grants at most one access (read or write) per cycle using round-robin arbitration.
- Drives the BRAM's write and read ports and returns read data with a per-requester valid strobe.
- The instantiating level ties both BRAM clocks (wrclock, rdclock) to this block's clock.

Parameters:
- DATA_WIDTH, 8, word width of the BRAM and of each requester's data.
- DEPTH, 256, number of BRAM words.
- NUM_REQ, 2, number of requesters (2..8). Index 0 is the CPU by convention.
- ADDRESS_WIDTH (localparam), $clog2(DEPTH), address width.

Ports:
- clock  in  1  single clock for arbiter and BRAM.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request, level.
- we  in  NUM_REQ  per-requester write (1) / read (0) select, valid with req.
- addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i occupies bits [i*AW +: AW].
- wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies bits [i*DW +: DW].
- gnt  out  NUM_REQ  one-hot grant; the access is performed this cycle.
- rvalid  out  NUM_REQ  one-hot; read data is on rdata this cycle.
- rdata  out  DATA_WIDTH  read data, broadcast to all requesters.
- bram_data  out  DATA_WIDTH  to BRAM data.
- bram_wraddress  out  ADDRESS_WIDTH  to BRAM wraddress.
- bram_wren  out  1  to BRAM wren.
- bram_rdaddress  out  ADDRESS_WIDTH  to BRAM rdaddress.
- bram_q  in  DATA_WIDTH  from BRAM q.

Behaviour:
- State:
  - last (index of the most recent grantee, log2(NUM_REQ) bits).
  - rd_pend (NUM_REQ bits, one-hot or zero): which requester's read is returning.
- Reset (resetn low, asynchronous):
  - last = NUM_REQ-1, so requester 0 wins the first contention.
  - rd_pend = 0.
  - While resetn is low, gnt, bram_wren and rvalid are forced to 0.
  - A read in flight when reset asserts is dropped; its rvalid never fires.
- Arbitration (combinational, Mealy):
  - Winner = first i with req[i]=1, scanning last+1, last+2, … modulo NUM_REQ.
  - gnt = onehot(winner), or 0 if there are no requests.
  - On any clock edge with a grant, last <= winner. With no grant, last holds.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high. The transfer completes at the edge ending that cycle.
  - Deasserting req before gnt is legal; the request is simply withdrawn.
  - Holding req after gnt issues a new, independent access; it is granted again when round-robin allows.
- Write grant (we=1):
  - bram_wren=1, bram_wraddress=addr[winner], bram_data=wdata[winner] in the same cycle.
  - The write takes effect at that clock edge.
- Read grant (we=0):
  - bram_rdaddress=addr[winner], bram_wren=0.
  - rd_pend <= onehot(winner).
  - Next cycle: rvalid = rd_pend, rdata = bram_q. Read latency is exactly 1 cycle after gnt.
- Idle cycle:
  - bram_wren=0.
  - bram_rdaddress, bram_wraddress and bram_data hold the previous winner's values (no glitch requirement, but they must be deterministic).
  - rd_pend <= 0.
- rvalid and rdata:
  - rdata is bram_q at all times; it is meaningful only when rvalid != 0.
  - rvalid is at most one-hot. Reads are granted one per cycle, so rvalid can be high in consecutive cycles for different requesters.
- Ordering / hazards:
  - Only one access per cycle, so there is never a same-cycle read/write collision.
  - A write at cycle N followed by a read of the same address at cycle N+1 returns the new data.
- Fairness: with all requesters continuously requesting, each is granted exactly once every NUM_REQ cycles. Worst-case wait is NUM_REQ-1 cycles.
- Single requester: granted every cycle it requests, with full throughput and no bubbles.

Test Plan:
- Reset then single write/read: req0 writes 0xA5 at addr 0x10; next cycle req0 reads 0x10 → gnt[0] in both cycles; rvalid[0]=1 with rdata=0xA5 one cycle after the read grant.
- Contention after reset: req[0] and req[1] both asserted (reads of 0x01 and 0x02, preloaded 0x11/0x22) → gnt order 0,1,0,1…; rvalid alternates 01,10 with rdata 0x11,0x22.
- Round-robin fairness, NUM_REQ=4: all four hold req for 16 cycles → each gnt bit is high exactly 4 times, in order 0,1,2,3 repeating; no requester waits more than 3 cycles.
- Write-then-read across requesters: req1 writes 0x3C at 0x80 in cycle N, req0 reads 0x80 in cycle N+1 → rvalid[0] at N+2 with rdata=0x3C.
- Reset mid-read: read granted to req1, resetn pulled low before the next edge → rvalid stays 0 and never fires for that read; after release the first contention grants req0.
- Withdrawn request: req1 asserted while req0 holds the grant, req1 drops before being granted → no gnt[1], no write occurs, BRAM contents unchanged.
